keccak_absorb_ctrl: RTL and testbench

KECCAK_ABSORB_CTRL -- requirements
Module: keccak_absorb_ctrl

---
 rtl/keccak_pkg.sv | 28 ++
 rtl/keccak_absorb_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_keccak_absorb_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keccak_pkg.sv
// Shared constants, FSM state type and helpers for the Keccak absorb controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package keccak_pkg;

  localparam int DWIDTH            = 256;
  localparam int KEEP_WIDTH        = 32;
  localparam int RATE_WIDTH        = 11;
  localparam int BYTE_ABSORB_WIDTH = 8;
  localparam int CARRY_WIDTH       = 256;
  localparam int CARRY_KEEP_WIDTH  = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ABSORB,
    ST_PERMUTE,
    ST_CARRY,
    ST_PAD,
    ST_FINAL_PERM,
    ST_DONE
  } absorb_state_t;

  // Rate is carried in bits; the fill offset is counted in bytes.
  function automatic logic [BYTE_ABSORB_WIDTH-1:0] rate_bytes(input logic [RATE_WIDTH-1:0] rate_bits);
    return BYTE_ABSORB_WIDTH'(rate_bits >> 3);
  endfunction

endpackage

// File: rtl/keccak_absorb_ctrl.sv
// Sequences message beats into the Keccak absorb datapath: feeds beats, handles
//   rate-boundary carry, requests permutations, then pads and runs the final permutation.
// Latency: beat committed in its handshake cycle; absorb_done_o one cycle after final perm_done_i.
// Backpressure: s_ready_o high only in ABSORB; low while permuting, replaying carry or padding.
//
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   start_i, rate_i                  begin message (IDLE only), rate in bits
//   s_valid_i/s_ready_o/s_data_i/s_keep_i/s_last_i   message beat stream
//   dp_msg_o, dp_keep_o, dp_bytes_absorbed_o         to absorb datapath
//   dp_bytes_absorbed_i, dp_has_carry_i, dp_carry_i, dp_carry_keep_i  from datapath
//   state_we_o, pad_valid_o, pad_offset_o            datapath commit / padding control
//   perm_start_o, perm_done_i        permutation request / completion
//   absorb_done_o                    one-cycle end-of-absorb pulse
module keccak_absorb_ctrl
  import keccak_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [RATE_WIDTH-1:0]        rate_i,
  input  logic                         s_valid_i,
  output logic                         s_ready_o,
  input  logic [DWIDTH-1:0]            s_data_i,
  input  logic [KEEP_WIDTH-1:0]        s_keep_i,
  input  logic                         s_last_i,
  output logic [DWIDTH-1:0]            dp_msg_o,
  output logic [KEEP_WIDTH-1:0]        dp_keep_o,
  output logic [BYTE_ABSORB_WIDTH-1:0] dp_bytes_absorbed_o,
  input  logic [BYTE_ABSORB_WIDTH-1:0] dp_bytes_absorbed_i,
  input  logic                         dp_has_carry_i,
  input  logic [CARRY_WIDTH-1:0]       dp_carry_i,
  input  logic [CARRY_KEEP_WIDTH-1:0]  dp_carry_keep_i,
  output logic                         state_we_o,
  output logic                         pad_valid_o,
  output logic [BYTE_ABSORB_WIDTH-1:0] pad_offset_o,
  output logic                         perm_start_o,
  input  logic                         perm_done_i,
  output logic                         absorb_done_o
);

  absorb_state_t                r_state, w_state_nxt;
  logic [RATE_WIDTH-1:0]        r_rate, w_rate_nxt;
  logic [BYTE_ABSORB_WIDTH-1:0] r_offset, w_offset_nxt;
  logic                         r_last_seen, w_last_seen_nxt;
  logic                         r_carry_pending, w_carry_pending_nxt;
  logic [CARRY_WIDTH-1:0]       r_carry, w_carry_nxt;
  logic [CARRY_KEEP_WIDTH-1:0]  r_carry_keep, w_carry_keep_nxt;
  // Set once the permutation request has been issued; marks the first cycle
  // of PERMUTE/FINAL_PERM and gates perm_done_i to after the request.
  logic                         r_perm_sent, w_perm_sent_nxt;
  logic [BYTE_ABSORB_WIDTH-1:0] w_rate_bytes;

  assign w_rate_bytes = rate_bytes(r_rate);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state         <= ST_IDLE;
      r_rate          <= '0;
      r_offset        <= '0;
      r_last_seen     <= 1'b0;
      r_carry_pending <= 1'b0;
      r_carry         <= '0;
      r_carry_keep    <= '0;
      r_perm_sent     <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_rate          <= w_rate_nxt;
      r_offset        <= w_offset_nxt;
      r_last_seen     <= w_last_seen_nxt;
      r_carry_pending <= w_carry_pending_nxt;
      r_carry         <= w_carry_nxt;
      r_carry_keep    <= w_carry_keep_nxt;
      r_perm_sent     <= w_perm_sent_nxt;
    end
  end

  always_comb begin
    w_state_nxt         = r_state;
    w_rate_nxt          = r_rate;
    w_offset_nxt        = r_offset;
    w_last_seen_nxt     = r_last_seen;
    w_carry_pending_nxt = r_carry_pending;
    w_carry_nxt         = r_carry;
    w_carry_keep_nxt    = r_carry_keep;
    w_perm_sent_nxt     = r_perm_sent;
    s_ready_o           = 1'b0;
    dp_msg_o            = '0;
    dp_keep_o           = '0;
    dp_bytes_absorbed_o = '0;
    state_we_o          = 1'b0;
    pad_valid_o         = 1'b0;
    pad_offset_o        = '0;
    perm_start_o        = 1'b0;
    absorb_done_o       = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_rate_nxt          = rate_i;
          w_offset_nxt        = '0;
          w_last_seen_nxt     = 1'b0;
          w_carry_pending_nxt = 1'b0;
          w_state_nxt         = ST_ABSORB;
        end
      end

      ST_ABSORB: begin
        s_ready_o           = 1'b1;
        dp_bytes_absorbed_o = r_offset;
        if (s_valid_i) begin
          dp_msg_o        = s_data_i;
          dp_keep_o       = s_keep_i;
          state_we_o      = 1'b1;
          w_offset_nxt    = dp_bytes_absorbed_i;
          w_last_seen_nxt = r_last_seen | s_last_i;
          // Carry outranks an exact fill: the tail must be replayed after the permutation.
          if (dp_has_carry_i) begin
            w_carry_nxt         = dp_carry_i;
            w_carry_keep_nxt    = dp_carry_keep_i;
            w_carry_pending_nxt = 1'b1;
            w_state_nxt         = ST_PERMUTE;
          end else if (dp_bytes_absorbed_i == w_rate_bytes) begin
            w_state_nxt = ST_PERMUTE;
          end else if (s_last_i) begin
            w_state_nxt = ST_PAD;
          end
        end
      end

      ST_PERMUTE: begin
        perm_start_o    = ~r_perm_sent;
        w_perm_sent_nxt = 1'b1;
        if (r_perm_sent && perm_done_i) begin
          w_perm_sent_nxt = 1'b0;
          w_offset_nxt    = '0;
          if (r_carry_pending) begin
            w_state_nxt = ST_CARRY;
          end else if (r_last_seen) begin
            w_state_nxt = ST_PAD;
          end else begin
            w_state_nxt = ST_ABSORB;
          end
        end
      end

      ST_CARRY: begin
        dp_msg_o            = DWIDTH'(r_carry);
        dp_keep_o           = KEEP_WIDTH'(r_carry_keep);
        dp_bytes_absorbed_o = r_offset;
        state_we_o          = 1'b1;
        w_offset_nxt        = dp_bytes_absorbed_i;
        w_carry_pending_nxt = 1'b0;
        w_state_nxt         = r_last_seen ? ST_PAD : ST_ABSORB;
      end

      ST_PAD: begin
        pad_valid_o  = 1'b1;
        state_we_o   = 1'b1;
        pad_offset_o = r_offset;
        w_state_nxt  = ST_FINAL_PERM;
      end

      ST_FINAL_PERM: begin
        perm_start_o    = ~r_perm_sent;
        w_perm_sent_nxt = 1'b1;
        if (r_perm_sent && perm_done_i) begin
          w_perm_sent_nxt = 1'b0;
          w_state_nxt     = ST_DONE;
        end
      end

      ST_DONE: begin
        absorb_done_o = 1'b1;
        w_state_nxt   = ST_IDLE;
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_keccak_absorb_ctrl.sv
// Self-checking bench for keccak_absorb_ctrl: message-level event model plus datapath/permutation stubs.
// Latency: n/a.
// Backpressure: beats held valid until accepted; permutation latency fixed or random.
module tb_keccak_absorb_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [10:0]  rate = '0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [255:0] s_data = '0;
  logic [31:0]  s_keep = '0;
  logic         s_last = 1'b0;
  logic [255:0] dp_msg;
  logic [31:0]  dp_keep;
  logic [7:0]   dp_off_out;
  logic [7:0]   dp_off_in;
  logic         dp_has_carry;
  logic [255:0] dp_carry;
  logic [23:0]  dp_carry_keep;
  logic         state_we, pad_valid, perm_start, absorb_done;
  logic [7:0]   pad_offset;
  logic         perm_done = 1'b0;

  always #5 clk = ~clk;

  keccak_absorb_ctrl dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .rate_i(rate),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data), .s_keep_i(s_keep), .s_last_i(s_last),
    .dp_msg_o(dp_msg), .dp_keep_o(dp_keep), .dp_bytes_absorbed_o(dp_off_out),
    .dp_bytes_absorbed_i(dp_off_in), .dp_has_carry_i(dp_has_carry), .dp_carry_i(dp_carry),
    .dp_carry_keep_i(dp_carry_keep), .state_we_o(state_we), .pad_valid_o(pad_valid),
    .pad_offset_o(pad_offset), .perm_start_o(perm_start), .perm_done_i(perm_done),
    .absorb_done_o(absorb_done)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name, input string why);
    n_chk++;
    n_fail++;
    $display("FAIL %s: %s", name, why);
  endtask

  // Absorb datapath stub: bytes land at the offset, overflow past the rate becomes carry.
  int cur_rb = 136;
  int dp_n, dp_sum, dp_cb;
  always_comb begin
    dp_n          = $countones(dp_keep);
    dp_sum        = int'(dp_off_out) + dp_n;
    dp_cb         = 0;
    dp_has_carry  = 1'b0;
    dp_carry      = '0;
    dp_carry_keep = '0;
    dp_off_in     = 8'(dp_sum);
    if (dp_sum > cur_rb) begin
      dp_cb         = dp_sum - cur_rb;
      dp_has_carry  = 1'b1;
      dp_off_in     = 8'(cur_rb);
      dp_carry      = dp_msg >> ((dp_n - dp_cb) * 8);
      dp_carry_keep = 24'((32'h1 << dp_cb) - 1);
    end
  end

  // Expected observable events, in order.
  localparam int EV_WRITE = 0, EV_PERM = 1, EV_PAD = 2, EV_DONE = 3;
  typedef struct {
    int           kind;
    logic [255:0] dat;
    logic [31:0]  keep;
    int           off;
  } ev_t;
  ev_t exp_q[$];

  bit   chk_en = 1'b0;
  bit   resp_en = 1'b0;
  bit   perm_pend = 1'b0;
  int   perm_cnt = 0;
  int   lat_fixed = 0;
  int   obs_writes, obs_perms, obs_pad_off, obs_max_off;
  ev_t  cmp_e;
  int   cmp_nev, cmp_kind;

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_nev = int'(perm_start) + int'(absorb_done) + int'(pad_valid) + int'(state_we && !pad_valid);
      if (cmp_nev > 1) begin
        flag_fail("multi_event", "more than one event in a cycle");
      end else if (cmp_nev == 1) begin
        cmp_kind = perm_start ? EV_PERM : absorb_done ? EV_DONE : pad_valid ? EV_PAD : EV_WRITE;
        if (cmp_kind == EV_WRITE) begin
          obs_writes++;
          if (int'(dp_off_out) > obs_max_off) obs_max_off = int'(dp_off_out);
        end
        if (cmp_kind == EV_PERM) obs_perms++;
        if (cmp_kind == EV_PAD) obs_pad_off = int'(pad_offset);
        if (exp_q.size() == 0) begin
          flag_fail("unexpected_event", $sformatf("kind %0d with nothing expected", cmp_kind));
        end else begin
          cmp_e = exp_q.pop_front();
          chk("event_kind", 256'(cmp_kind), 256'(cmp_e.kind));
          if (cmp_kind == cmp_e.kind && cmp_kind == EV_WRITE) begin
            chk("write_data", dp_msg, cmp_e.dat);
            chk("write_keep", 256'(dp_keep), 256'(cmp_e.keep));
            chk("write_offset", 256'(dp_off_out), 256'(cmp_e.off));
          end
          if (cmp_kind == cmp_e.kind && cmp_kind == EV_PAD) begin
            chk("pad_offset", 256'(pad_offset), 256'(cmp_e.off));
            chk("pad_state_we", 256'(state_we), 256'(1));
            chk("pad_msg_zero", {dp_msg[223:0], dp_keep}, 256'(0));
          end
        end
      end
      if (!state_we) chk("dp_idle_zero", {dp_msg[223:0], dp_keep}, 256'(0));
      if (perm_pend) chk("ready_during_perm", 256'(s_ready), 256'(0));
    end
    if (resp_en) begin
      perm_done = 1'b0;
      if (perm_pend) begin
        perm_cnt--;
        if (perm_cnt <= 0) begin
          perm_done = 1'b1;
          perm_pend = 1'b0;
        end
      end else if (perm_start) begin
        perm_pend = 1'b1;
        perm_cnt  = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 12));
      end else if ($urandom_range(0, 5) == 0) begin
        perm_done = 1'b1;  // stray completion, must be ignored
      end
    end
  end

  int lens_q[$];

  function automatic logic [31:0] keep_of(input int n);
    logic [31:0] ones = 32'hFFFF_FFFF;
    return (n == 0) ? 32'h0 : (ones >> (32 - n));
  endfunction

  task automatic run_msg(input int rate_bits, input int lat, input bit stray_start);
    logic [255:0] bd[$];
    logic [31:0]  bk[$];
    logic [255:0] ones = '1;
    logic [255:0] d;
    ev_t e;
    int rb, off, sum, cb, n, cyc;
    bit hs;
    rb = rate_bits / 8;
    off = 0;
    foreach (lens_q[i]) begin
      n = lens_q[i];
      d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      d = (n == 0) ? '0 : (d & (ones >> (256 - 8 * n)));
      bd.push_back(d);
      bk.push_back(keep_of(n));
      e.kind = EV_WRITE; e.dat = d; e.keep = keep_of(n); e.off = off;
      exp_q.push_back(e);
      sum = off + n;
      if (sum > rb) begin
        cb = sum - rb;
        e.kind = EV_PERM; exp_q.push_back(e);
        e.kind = EV_WRITE; e.dat = d >> ((n - cb) * 8); e.keep = keep_of(cb); e.off = 0;
        exp_q.push_back(e);
        off = cb;
      end else if (sum == rb) begin
        e.kind = EV_PERM; exp_q.push_back(e);
        off = 0;
      end else begin
        off = sum;
      end
    end
    e.kind = EV_PAD; e.off = off; e.dat = '0; e.keep = '0; exp_q.push_back(e);
    e.kind = EV_PERM; exp_q.push_back(e);
    e.kind = EV_DONE; exp_q.push_back(e);

    cur_rb = rb; lat_fixed = lat;
    obs_writes = 0; obs_perms = 0; obs_pad_off = -1; obs_max_off = 0;
    @(posedge clk); #1;
    rate = 11'(rate_bits); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < bd.size(); i++) begin
      s_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      s_valid = 1'b1; s_data = bd[i]; s_keep = bk[i]; s_last = (i == bd.size() - 1);
      cyc = 0; hs = 1'b0;
      while (!hs && cyc < 500) begin
        start = stray_start && ($urandom_range(0, 3) == 0) && !s_last;
        @(negedge clk); hs = s_ready;
        @(posedge clk); #1; cyc++;
      end
      start = 1'b0;
      if (!hs) flag_fail("beat_accept_timeout", $sformatf("beat %0d not accepted", i));
    end
    s_valid = 1'b0; s_last = 1'b0; s_keep = '0; s_data = '0;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 3000) begin @(posedge clk); cyc++; end
    if (exp_q.size() != 0) flag_fail("msg_done_timeout", $sformatf("%0d events missing", exp_q.size()));
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {s_ready, dp_msg[191:0], dp_keep, dp_off_out, state_we, pad_valid, pad_offset, perm_start, absorb_done},
        256'(0));
    chk({name, "_msg_hi"}, 256'(dp_msg[255:192]), 256'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int rates[5] = '{1088, 576, 1152, 832, 1344};
    int rb, off, n, sum, cyc;
    bit seen;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); chk_all_zero("reset_outputs");
    #1; @(posedge clk); #1; rst = 1'b0;
    @(negedge clk); chk_all_zero("idle_outputs");

    chk_en = 1'b1; resp_en = 1'b1;

    // SHA3-256: five full beats, carry of 24, delayed permutation with beat held valid
    lens_q = '{32, 32, 32, 32, 32};
    run_msg(1088, 24, 1'b0);
    chk("sha256_pad_off", 256'(obs_pad_off), 256'(24));
    chk("sha256_writes", 256'(obs_writes), 256'(6));
    chk("sha256_perms", 256'(obs_perms), 256'(2));
    chk("sha256_max_off", 256'(obs_max_off), 256'(128));

    // SHA3-512: exact fill on last beat -> PERMUTE then PAD at 0
    lens_q = '{32, 32, 8};
    run_msg(576, 0, 1'b0);
    chk("sha512_pad_off", 256'(obs_pad_off), 256'(0));
    chk("sha512_writes", 256'(obs_writes), 256'(3));
    chk("sha512_perms", 256'(obs_perms), 256'(2));
    chk("sha512_max_off", 256'(obs_max_off), 256'(64));

    // Single short last beat
    lens_q = '{5};
    run_msg(1088, 0, 1'b1);
    chk("short_pad_off", 256'(obs_pad_off), 256'(5));
    chk("short_writes", 256'(obs_writes), 256'(1));
    chk("short_perms", 256'(obs_perms), 256'(1));

    // Zero-keep last beat at offset 40
    lens_q = '{32, 8, 0};
    run_msg(1088, 0, 1'b0);
    chk("zkeep_pad_off", 256'(obs_pad_off), 256'(40));
    chk("zkeep_writes", 256'(obs_writes), 256'(3));
    chk("zkeep_max_off", 256'(obs_max_off), 256'(40));

    // Randomized messages
    for (int m = 0; m < 14; m++) begin
      rb = rates[$urandom_range(0, 4)] / 8;
      lens_q.delete();
      off = 0;
      for (int b = 0; b < int'($urandom_range(1, 8)); b++) begin
        n = ($urandom_range(0, 1) == 1) ? 32 : int'($urandom_range(0, 32));
        if (off + n - rb > 24) n = rb + 24 - off;
        lens_q.push_back(n);
        sum = off + n;
        off = (sum > rb) ? sum - rb : (sum == rb) ? 0 : sum;
      end
      run_msg(rb * 8, 0, 1'b1);
    end

    // Reset in the middle of a permutation; late perm_done_i must be ignored
    chk_en = 1'b0; resp_en = 1'b0; perm_done = 1'b0;
    cur_rb = 32;
    @(posedge clk); #1; rate = 11'd256; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    s_valid = 1'b1; s_data = '1; s_keep = 32'hFFFF_FFFF; s_last = 1'b0;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 50) begin @(negedge clk); seen = perm_start; @(posedge clk); #1; cyc++; end
    chk("rst_test_perm_started", 256'(seen), 256'(1));
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk); chk_all_zero("rst_mid_perm");
    @(posedge clk); #1; perm_done = 1'b1;
    @(posedge clk); #1; perm_done = 1'b0;
    for (int k = 0; k < 3; k++) begin @(negedge clk); chk_all_zero("late_done_ignored"); end
    s_valid = 1'b0; s_data = '0; s_keep = '0;
    @(posedge clk); #1;

    perm_pend = 1'b0; chk_en = 1'b1; resp_en = 1'b1;
    lens_q = '{32, 32, 32, 32, 32};
    run_msg(1088, 0, 1'b0);
    chk("post_rst_pad_off", 256'(obs_pad_off), 256'(24));
    chk("post_rst_perms", 256'(obs_perms), 256'(2));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
